// File: rtl/bus_arbiter.sv
// Purpose: shares one bus between instruction fetch and load/store, MEM first.
// Latency: request at cycle N -> bus_req from N+1; bus_ack at M -> done at M+1.
// Backpressure: requesters stall via stallreq_* until done; no preemption.
module bus_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce,
    input  logic [31:0] if_addr,
    input  logic        flush,
    input  logic        mem_ce,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        stallreq_if,
    output logic        stallreq_mem
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2,
        IF_FLUSH = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        bus_req_nxt;
    logic        bus_we_nxt;
    logic [31:0] bus_addr_nxt;
    logic [3:0]  bus_sel_nxt;
    logic [31:0] bus_wdata_nxt;
    logic [31:0] if_rdata_nxt;
    logic        if_done_nxt;
    logic [31:0] mem_rdata_nxt;
    logic        mem_done_nxt;

    // A requester is still released by its done pulse during the first IDLE
    // cycle, so that cycle must not re-grant the request that just finished.
    logic        mem_pending;
    logic        if_pending;

    assign mem_pending  = mem_ce & ~mem_done;
    assign if_pending   = if_ce & ~if_done;
    assign stallreq_mem = mem_pending;
    assign stallreq_if  = if_pending;

    // Next-state and next-output decode; bus fields hold unless a grant loads them.
    always_comb begin
        state_nxt     = state;
        bus_req_nxt   = bus_req;
        bus_we_nxt    = bus_we;
        bus_addr_nxt  = bus_addr;
        bus_sel_nxt   = bus_sel;
        bus_wdata_nxt = bus_wdata;
        if_rdata_nxt  = if_rdata;
        mem_rdata_nxt = mem_rdata;
        if_done_nxt   = 1'b0;
        mem_done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (mem_pending) begin
                    state_nxt     = MEM_BUSY;
                    bus_req_nxt   = 1'b1;
                    bus_we_nxt    = mem_we;
                    bus_addr_nxt  = mem_addr;
                    bus_sel_nxt   = mem_sel;
                    bus_wdata_nxt = mem_wdata;
                end else if (if_pending) begin
                    state_nxt     = IF_BUSY;
                    bus_req_nxt   = 1'b1;
                    bus_we_nxt    = 1'b0;
                    bus_addr_nxt  = if_addr;
                    bus_sel_nxt   = 4'b1111;
                end else begin
                    bus_req_nxt   = 1'b0;
                end
            end

            MEM_BUSY: begin
                if (bus_ack) begin
                    state_nxt    = IDLE;
                    bus_req_nxt  = 1'b0;
                    mem_done_nxt = 1'b1;
                    if (!bus_we) begin
                        mem_rdata_nxt = bus_rdata;
                    end
                end
            end

            IF_BUSY: begin
                if (bus_ack) begin
                    state_nxt   = IDLE;
                    bus_req_nxt = 1'b0;
                    if (!flush) begin
                        if_rdata_nxt = bus_rdata;
                        if_done_nxt  = 1'b1;
                    end
                end else if (flush) begin
                    state_nxt = IF_FLUSH;
                end
            end

            IF_FLUSH: begin
                // The bus cycle must still complete; its data is dropped.
                if (bus_ack) begin
                    state_nxt   = IDLE;
                    bus_req_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt   = IDLE;
                bus_req_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs, cleared by synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_sel   <= 4'd0;
            bus_wdata <= 32'd0;
            if_rdata  <= 32'd0;
            if_done   <= 1'b0;
            mem_rdata <= 32'd0;
            mem_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            bus_req   <= bus_req_nxt;
            bus_we    <= bus_we_nxt;
            bus_addr  <= bus_addr_nxt;
            bus_sel   <= bus_sel_nxt;
            bus_wdata <= bus_wdata_nxt;
            if_rdata  <= if_rdata_nxt;
            if_done   <= if_done_nxt;
            mem_rdata <= mem_rdata_nxt;
            mem_done  <= mem_done_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Purpose: self-checking bench for bus_arbiter, directed scenarios plus random transactions.
// Latency: each transaction is checked cycle by cycle against a transaction-level model.
// Backpressure: the bench plays both requesters and a bus slave with random wait states.
module tb_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        if_ce;
    logic [31:0] if_addr;
    logic        flush;
    logic        mem_ce;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] if_rdata;
    logic        if_done;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        stallreq_if;
    logic        stallreq_mem;

    int          checks;
    int          errors;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_mem_rdata;

    bus_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .if_ce        (if_ce),
        .if_addr      (if_addr),
        .flush        (flush),
        .mem_ce       (mem_ce),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_sel      (mem_sel),
        .mem_wdata    (mem_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_sel      (bus_sel),
        .bus_wdata    (bus_wdata),
        .if_rdata     (if_rdata),
        .if_done      (if_done),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done),
        .stallreq_if  (stallreq_if),
        .stallreq_mem (stallreq_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are read 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic quiet_inputs();
        if_ce     = 1'b0;
        if_addr   = 32'd0;
        flush     = 1'b0;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_sel   = 4'd0;
        mem_wdata = 32'd0;
        bus_rdata = 32'd0;
        bus_ack   = 1'b0;
    endtask

    // One transaction from an idle arbiter. wt = wait cycles before ack.
    // fmode (fetch only): 0 none, 1 flush before the ack (or with it if wt=0),
    // 2 flush in the same cycle as the ack.
    task automatic run_txn(input bit is_mem, input bit we, input logic [31:0] addr,
                           input logic [3:0] sel, input logic [31:0] wdata,
                           input logic [31:0] rd, input int wt, input int fmode);
        int fl_at;
        bit flushed;
        flushed = 1'b0;
        fl_at   = -1;
        if (!is_mem && fmode == 1) fl_at = (wt > 0) ? 0 : wt;
        if (!is_mem && fmode == 2) fl_at = wt;
        if (is_mem) begin
            mem_ce = 1'b1; mem_we = we; mem_addr = addr; mem_sel = sel; mem_wdata = wdata;
        end else begin
            if_ce = 1'b1; if_addr = addr;
        end
        #1;
        chk1("stall_raise", is_mem ? stallreq_mem : stallreq_if, 1'b1);
        step();
        for (int k = 0; k <= wt; k++) begin
            chk1("bus_req_held", bus_req, 1'b1);
            chk32("bus_addr", bus_addr, addr);
            chk1("bus_we", bus_we, is_mem ? we : 1'b0);
            chk32("bus_sel", {28'd0, bus_sel}, {28'd0, (is_mem ? sel : 4'hf)});
            if (is_mem) chk32("bus_wdata", bus_wdata, wdata);
            chk1("done_early", is_mem ? mem_done : if_done, 1'b0);
            if (flushed) if_ce = 1'b0;
            flush = (k == fl_at);
            if (k == fl_at) flushed = 1'b1;
            bus_ack   = (k == wt);
            bus_rdata = (k == wt) ? rd : $urandom;
            step();
        end
        bus_ack = 1'b0;
        flush   = 1'b0;
        if (is_mem) begin
            if (!we) exp_mem_rdata = rd;
            chk1("mem_done", mem_done, 1'b1);
            chk32("mem_rdata", mem_rdata, exp_mem_rdata);
            chk1("stall_mem_release", stallreq_mem, 1'b0);
            chk1("if_done_quiet", if_done, 1'b0);
            mem_ce = 1'b0;
        end else begin
            if (!flushed) begin
                exp_if_rdata = rd;
                chk1("stall_if_release", stallreq_if, 1'b0);
            end
            chk1("if_done", if_done, !flushed);
            chk32("if_rdata", if_rdata, exp_if_rdata);
            chk1("mem_done_quiet", mem_done, 1'b0);
            if_ce = 1'b0;
        end
        chk1("bus_req_drop", bus_req, 1'b0);
        step();
        chk1("done_one_cycle", mem_done | if_done, 1'b0);
        chk1("idle_no_req", bus_req, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        quiet_inputs();
        rst = 1'b0;
        step();
        step();
        // Reset state
        chk1("rst_bus_req", bus_req, 1'b0);
        chk1("rst_bus_we", bus_we, 1'b0);
        chk32("rst_bus_addr", bus_addr, 32'd0);
        chk32("rst_bus_sel", {28'd0, bus_sel}, 32'd0);
        chk32("rst_bus_wdata", bus_wdata, 32'd0);
        chk32("rst_if_rdata", if_rdata, 32'd0);
        chk32("rst_mem_rdata", mem_rdata, 32'd0);
        chk1("rst_if_done", if_done, 1'b0);
        chk1("rst_mem_done", mem_done, 1'b0);
        exp_if_rdata  = 32'd0;
        exp_mem_rdata = 32'd0;
        rst = 1'b1;

        // A stray ack in IDLE does nothing
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_0000;
        step();
        bus_ack = 1'b0;
        step();
        chk1("idle_ack_req", bus_req, 1'b0);
        chk1("idle_ack_done", if_done | mem_done, 1'b0);
        chk32("idle_ack_mem_rdata", mem_rdata, 32'd0);

        // Zero-wait fetch
        run_txn(1'b0, 1'b0, 32'h0000_0100, 4'h0, 32'd0, 32'h2402_0005, 0, 0);

        // Contention: MEM wins, IF follows after one IDLE cycle
        if_ce = 1'b1; if_addr = 32'h0000_0200;
        mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0080; mem_sel = 4'hf; mem_wdata = 32'd0;
        step();
        chk1("cont_mem_req", bus_req, 1'b1);
        chk32("cont_mem_addr", bus_addr, 32'h0000_0080);
        chk1("cont_stall_if", stallreq_if, 1'b1);
        bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
        step();
        chk1("cont_mem_done", mem_done, 1'b1);
        chk32("cont_mem_rdata", mem_rdata, 32'h1111_2222);
        chk1("cont_idle_gap", bus_req, 1'b0);
        exp_mem_rdata = 32'h1111_2222;
        bus_ack = 1'b0; mem_ce = 1'b0;
        step();
        chk1("cont_if_req", bus_req, 1'b1);
        chk32("cont_if_addr", bus_addr, 32'h0000_0200);
        chk32("cont_if_sel", {28'd0, bus_sel}, 32'hf);
        bus_ack = 1'b1; bus_rdata = 32'h3333_4444;
        step();
        chk1("cont_if_done", if_done, 1'b1);
        chk32("cont_if_rdata", if_rdata, 32'h3333_4444);
        exp_if_rdata = 32'h3333_4444;
        bus_ack = 1'b0; if_ce = 1'b0;
        step();

        // Store with ack three cycles late; mem_rdata must not move
        run_txn(1'b1, 1'b1, 32'h0000_0040, 4'b0011, 32'hDEAD_BEEF, 32'hBAD0_BAD0, 3, 0);
        // Flush in IF_BUSY, ack two cycles later
        run_txn(1'b0, 1'b0, 32'h0000_0300, 4'h0, 32'd0, 32'h5555_5555, 2, 1);
        // Flush coinciding with ack
        run_txn(1'b0, 1'b0, 32'h0000_0400, 4'h0, 32'd0, 32'h6666_6666, 0, 2);

        // Random traffic
        for (int t = 0; t < 150; t++) begin
            int kind;
            int wt;
            int fm;
            kind = int'($urandom_range(2, 0));
            wt   = int'($urandom_range(3, 0));
            fm   = int'($urandom_range(3, 0));
            if (fm == 3) fm = 0;
            if (kind == 2)
                run_txn(1'b0, 1'b0, $urandom, 4'h0, 32'd0, $urandom, wt, fm);
            else
                run_txn(1'b1, kind[0], $urandom, 4'($urandom), $urandom, $urandom, wt, 0);
        end

        // Reset in the middle of a MEM transaction
        mem_ce = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0044; mem_sel = 4'hf; mem_wdata = 32'h1234_5678;
        step();
        chk1("midrst_req_before", bus_req, 1'b1);
        rst = 1'b0;
        step();
        chk1("midrst_bus_req", bus_req, 1'b0);
        chk1("midrst_bus_we", bus_we, 1'b0);
        chk32("midrst_bus_addr", bus_addr, 32'd0);
        chk32("midrst_bus_sel", {28'd0, bus_sel}, 32'd0);
        chk32("midrst_bus_wdata", bus_wdata, 32'd0);
        chk32("midrst_if_rdata", if_rdata, 32'd0);
        chk32("midrst_mem_rdata", mem_rdata, 32'd0);
        rst = 1'b1; mem_ce = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
        step();
        bus_ack = 1'b0;
        chk1("midrst_late_ack_done", mem_done, 1'b0);
        chk32("midrst_late_ack_rdata", mem_rdata, 32'd0);
        chk1("midrst_late_ack_req", bus_req, 1'b0);
        step();
        chk1("midrst_still_idle", bus_req | mem_done | if_done, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
